// File: rtl/seq_pkg.sv
// Shared types and constants for the op_sequencer datapath.
// Opcodes, FSM state encoding, width constants and an opcode validity check.
package seq_pkg;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int OW = 3;
  localparam int NREGS = 1 << AW;

  localparam logic [OW-1:0] OP_AND   = 3'b000;
  localparam logic [OW-1:0] OP_OR    = 3'b001;
  localparam logic [OW-1:0] OP_ADD   = 3'b010;
  localparam logic [OW-1:0] OP_SUB   = 3'b011;
  localparam logic [OW-1:0] OP_LOADI = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  function automatic logic op_valid(input logic [OW-1:0] op);
    return op <= OP_LOADI;
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// 16x4 register file: two registered read ports, one write port, reset to 0.
// Ports: clk, rst, ren, raddr_a/b -> rdata_a/b, we, waddr, wdata.
// SEQ_R0_ZERO_EN: register 0 reads as 0 and ignores writes.
module seq_regfile
  import seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ren,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem [NREGS];
  logic          wr_ok;
  logic [DW-1:0] va;
  logic [DW-1:0] vb;

`ifdef SEQ_R0_ZERO_EN
  assign wr_ok = we && (waddr != '0);
  assign va = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign vb = (raddr_b == '0) ? '0 : mem[raddr_b];
`else
  assign wr_ok = we;
  assign va = mem[raddr_a];
  assign vb = mem[raddr_b];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (wr_ok) mem[waddr] <= wdata;
      // Read outputs double as the operand registers a/b,
      // so they only load in READ and hold afterwards.
      if (ren) begin
        rdata_a <= va;
        rdata_b <= vb;
      end
    end
  end

endmodule

// File: rtl/op_sequencer.sv
// Four-cycle instruction sequencer for the 4-bit ALU (IDLE/READ/EXEC/WRITE).
// Ports: instr_valid/instr_ready handshake, opcode/rd/rs1/rs2/imm fields,
// done/invalid pulses, held result and cf/zf/sf flags, busy.
// Build option SEQ_R0_ZERO_EN (in seq_regfile): hard-wired zero register 0.
module op_sequencer
  import seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [OW-1:0] opcode,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [DW-1:0] imm,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          cf,
  output logic          zf,
  output logic          sf,
  output logic          invalid,
  output logic          busy
);

  state_t        state;
  logic [OW-1:0] op_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rs1_q;
  logic [AW-1:0] rs2_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          op_ok;
  logic          we;

  logic [DW:0]   sum;
  logic [DW-1:0] diff;
  logic [DW-1:0] alu_res;
  logic          alu_cf;
  logic          alu_sf;

  assign instr_ready = (state == S_IDLE);
  assign busy = (state != S_IDLE);
  assign op_ok = op_valid(op_q);
  // result already holds this instruction's value by WRITE
  assign we = (state == S_WRITE) && op_ok;

  seq_regfile u_rf (
    .clk     (clk),
    .rst     (rst),
    .ren     (state == S_READ),
    .raddr_a (rs1_q),
    .raddr_b (rs2_q),
    .rdata_a (a),
    .rdata_b (b),
    .we      (we),
    .waddr   (rd_q),
    .wdata   (result)
  );

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    diff = a + ~b + 4'd1;
    alu_res = '0;
    alu_cf = 1'b0;
    alu_sf = 1'b0;
    case (op_q)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: {alu_cf, alu_res} = sum;
      OP_SUB: begin
        // sign-magnitude output: negate when bit 3 is set
        if (diff[DW-1]) begin
          alu_res = ~diff + 4'd1;
          alu_sf = 1'b1;
        end else begin
          alu_res = diff;
        end
      end
      OP_LOADI: alu_res = imm_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q <= '0;
      rd_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      done <= 1'b0;
      invalid <= 1'b0;
      result <= '0;
      cf <= 1'b0;
      zf <= 1'b0;
      sf <= 1'b0;
    end else begin
      done <= 1'b0;
      invalid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q <= opcode;
            rd_q <= rd;
            rs1_q <= rs1;
            rs2_q <= rs2;
            imm_q <= imm;
            state <= S_READ;
          end
        end
        S_READ: state <= S_EXEC;
        S_EXEC: begin
          if (op_ok) begin
            result <= alu_res;
            cf <= alu_cf;
            zf <= (alu_res == '0);
            sf <= alu_sf;
          end
          state <= S_WRITE;
        end
        S_WRITE: begin
          done <= 1'b1;
          invalid <= !op_ok;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer against an arithmetic reference model.
// Directed plan sequences, back-to-back handshake, reset abort, random ops.
module tb_op_sequencer;

  logic       clk = 0;
  logic       rst = 1;
  logic       instr_valid = 0;
  logic       instr_ready;
  logic [2:0] opcode = 0;
  logic [3:0] rd = 0;
  logic [3:0] rs1 = 0;
  logic [3:0] rs2 = 0;
  logic [3:0] imm = 0;
  logic       done;
  logic [3:0] result;
  logic       cf;
  logic       zf;
  logic       sf;
  logic       invalid;
  logic       busy;

  int n_tests = 0;
  int n_fail = 0;

  int m_rf [16];
  int m_res = 0, m_cf = 0, m_zf = 0, m_sf = 0, m_inv = 0;

  op_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .done(done), .result(result),
    .cf(cf), .zf(zf), .sf(sf),
    .invalid(invalid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rf_rd(input int i);
`ifdef SEQ_R0_ZERO_EN
    if (i == 0) return 0;
`endif
    return m_rf[i];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
    m_res = 0; m_cf = 0; m_zf = 0; m_sf = 0; m_inv = 0;
  endfunction

  function automatic void model(input int op, input int d, input int s1,
                                input int s2, input int im);
    int a, b, r, c, s, x;
    a = rf_rd(s1);
    b = rf_rd(s2);
    r = 0; c = 0; s = 0;
    m_inv = 0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: begin r = (a + b) % 16; c = (a + b > 15); end
      3: begin
        x = (a - b + 16) % 16;
        if (x >= 8) begin r = 16 - x; s = 1; end
        else r = x;
      end
      4: r = im;
      default: m_inv = 1;
    endcase
    if (!m_inv) begin
      m_res = r; m_cf = c; m_sf = s; m_zf = (r == 0);
      m_rf[d] = r;
    end
  endfunction

  function automatic int packed_exp();
    return m_res | (m_cf << 4) | (m_zf << 5) | (m_sf << 6) | (m_inv << 7);
  endfunction

  function automatic int packed_obs();
    return int'(result) | (int'(cf) << 4) | (int'(zf) << 5)
         | (int'(sf) << 6) | (int'(invalid) << 7);
  endfunction

  task automatic send(input int op, input int d, input int s1,
                      input int s2, input int im);
    int k;
    @(negedge clk);
    chk("ready", instr_ready, 1);
    opcode = 3'(op); rd = 4'(d); rs1 = 4'(s1); rs2 = 4'(s2); imm = 4'(im);
    instr_valid = 1;
    @(posedge clk);
    model(op, d, s1, s2, im);
    @(negedge clk);
    instr_valid = 0;
    k = 1;
    while (!done && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, 4);
    chk("result", result, m_res);
    chk("cf", cf, m_cf);
    chk("zf", zf, m_zf);
    chk("sf", sf, m_sf);
    chk("invalid", invalid, m_inv);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ready"}, instr_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_out"}, packed_obs(), 0);
  endtask

  int b_op [4];
  int b_rd [4];
  int b_s1 [4];
  int b_s2 [4];
  int b_im [4];
  int q_exp [$];

  initial begin
    int idx, since, accepts, dones, r, ndone;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check_idle_zero("reset");

    // ADD overflow to zero
    send(4, 1, 0, 0, 7);
    send(4, 2, 0, 0, 9);
    send(2, 3, 1, 2, 0);
    chk("plan_add_res", result, 0);
    chk("plan_add_cf", cf, 1);
    chk("plan_add_zf", zf, 1);

    // SUB both directions
    send(4, 4, 0, 0, 2);
    send(4, 5, 0, 0, 5);
    send(3, 6, 4, 5, 0);
    chk("plan_sub_neg", {28'd0, sf, result}, 16 + 3);
    send(3, 7, 5, 4, 0);
    chk("plan_sub_pos", {28'd0, sf, result}, 3);

    // logic ops and an illegal opcode
    send(4, 1, 0, 0, 12);
    send(4, 2, 0, 0, 10);
    send(0, 10, 1, 2, 0);
    chk("plan_and", result, 8);
    send(1, 11, 1, 2, 0);
    chk("plan_or", result, 14);
    send(6, 1, 2, 2, 0);
    chk("plan_inv_res", result, 14);
    send(1, 12, 1, 1, 0);

    // back-to-back with valid held high
    for (int i = 0; i < 4; i++) begin
      b_op[i] = (i == 0) ? 4 : $urandom_range(4, 0);
      b_rd[i] = $urandom_range(15, 0);
      b_s1[i] = $urandom_range(15, 0);
      b_s2[i] = $urandom_range(15, 0);
      b_im[i] = $urandom_range(15, 0);
    end
    idx = 0; since = 4; accepts = 0; dones = 0;
    for (int cyc = 0; cyc < 22; cyc++) begin
      @(negedge clk);
      if (since < 4) since++;
      r = instr_ready;
      chk("b2b_ready", r, since >= 4);
      if (done) begin
        dones++;
        if (q_exp.size() == 0) chk("b2b_extra_done", 1, 0);
        else chk("b2b_out", packed_obs(), q_exp.pop_front());
      end
      if (idx < 4) begin
        opcode = 3'(b_op[idx]); rd = 4'(b_rd[idx]);
        rs1 = 4'(b_s1[idx]); rs2 = 4'(b_s2[idx]); imm = 4'(b_im[idx]);
        instr_valid = 1;
      end else begin
        instr_valid = 0;
      end
      @(posedge clk);
      if (r && instr_valid) begin
        model(b_op[idx], b_rd[idx], b_s1[idx], b_s2[idx], b_im[idx]);
        q_exp.push_back(packed_exp());
        idx++;
        accepts++;
        since = 0;
      end
    end
    instr_valid = 0;
    chk("b2b_accepts", accepts, 4);
    chk("b2b_dones", dones, 4);

    // reset abort during EXEC
    send(4, 1, 0, 0, 12);
    send(4, 2, 0, 0, 10);
    @(negedge clk);
    opcode = 3'(2); rd = 4'(8); rs1 = 4'(1); rs2 = 4'(2);
    instr_valid = 1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 0;
    @(negedge clk);
    chk("abort_busy", busy, 1);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    check_idle_zero("abort");
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    send(2, 9, 8, 8, 0);
    chk("abort_r8_zf", zf, 1);

    // register 0 behaviour
    send(4, 0, 0, 0, 5);
    send(2, 1, 0, 0, 0);
`ifdef SEQ_R0_ZERO_EN
    chk("r0_add", result, 0);
`else
    chk("r0_add", result, 10);
`endif

    // random instructions
    for (int i = 0; i < 30; i++) begin
      send($urandom_range(7, 0), $urandom_range(15, 0),
           $urandom_range(15, 0), $urandom_range(15, 0),
           $urandom_range(15, 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
